// File: rtl/systolic_feeder.sv
// Skew/feed stage for an N x N systolic array: buffers one A/B operand pair,
// then streams it as a diagonal wavefront, drains with zeros, and pulses done.
module systolic_feeder #(
    parameter int unsigned W     = 16,
    parameter int unsigned N     = 3,
    parameter int unsigned DRAIN = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_mode,
    input  logic [W*N-1:0] i_a_col,
    input  logic [W*N-1:0] i_b_row,
    output logic           o_en,
    output logic           o_mode,
    output logic [W*N-1:0] o_A,
    output logic [W*N-1:0] o_B,
    output logic           o_busy,
    output logic           o_done
);

    localparam int unsigned CW     = $clog2(2 * N - 1 + DRAIN + 1);
    localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST_T = 2 * N - 2;

    typedef enum logic [1:0] {
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [KW-1:0]                k_q, k_d;
    logic [CW-1:0]                t_q, t_d;
    // buf_a is indexed [row i][k]; buf_b is indexed [k][col j]
    logic [N-1:0][N-1:0][W-1:0]   buf_a_q, buf_a_d;
    logic [N-1:0][N-1:0][W-1:0]   buf_b_q, buf_b_d;
    logic                         mode_q, mode_d;
    logic                         ready_q, ready_d;
    logic                         en_q, en_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [W*N-1:0]               a_out_q, a_out_d;
    logic [W*N-1:0]               b_out_q, b_out_d;

    // Next-state, buffer writes and registered-output precompute
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        mode_d  = mode_q;

        case (state_q)
            S_LOAD: begin
                if (i_valid) begin
                    for (int k = 0; k < N; k++) begin
                        if (k_q == KW'(k)) begin
                            for (int i = 0; i < N; i++) begin
                                buf_a_d[i][k] = i_a_col[i*W +: W];
                                buf_b_d[k][i] = i_b_row[i*W +: W];
                            end
                        end
                    end
                    if (k_q == '0) begin
                        mode_d = i_mode;
                    end
                    if (k_q == KW'(N - 1)) begin
                        k_d     = '0;
                        t_d     = '0;
                        state_d = S_STREAM;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_STREAM: begin
                if (t_q == CW'(LAST_T)) begin
                    t_d     = '0;
                    state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (t_q == CW'(DRAIN - 1)) begin
                    t_d     = '0;
                    state_d = S_DONE;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        ready_d = (state_d == S_LOAD);
        en_d    = (state_d == S_STREAM) || (state_d == S_DRAIN);
        busy_d  = (state_d != S_LOAD);
        done_d  = (state_d == S_DONE);
        a_out_d = '0;
        b_out_d = '0;
        // Lane i carries element k on wavefront step t = i + k; everything else is zero
        if (state_d == S_STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_d) == i + k) begin
                        a_out_d[i*W +: W] = buf_a_d[i][k];
                        b_out_d[i*W +: W] = buf_b_d[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_LOAD;
            k_q     <= '0;
            t_q     <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign o_ready = ready_q;
    assign o_en    = en_q;
    assign o_mode  = mode_q;
    assign o_A     = a_out_q;
    assign o_B     = b_out_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a 3x3/DRAIN=6 instance and a 2x2/DRAIN=0 instance,
// each compared every cycle against a matrix-level wavefront model.
module tb_systolic_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, valid0, mode0;
    logic [47:0] acol0, brow0;
    logic        ready0, en0, omode0, busy0, done0;
    logic [47:0] oa0, ob0;

    logic        rst1, valid1, mode1;
    logic [31:0] acol1, brow1;
    logic        ready1, en1, omode1, busy1, done1;
    logic [31:0] oa1, ob1;

    systolic_feeder #(.W(16), .N(3), .DRAIN(6)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_valid(valid0), .o_ready(ready0), .i_mode(mode0),
        .i_a_col(acol0), .i_b_row(brow0), .o_en(en0), .o_mode(omode0),
        .o_A(oa0), .o_B(ob0), .o_busy(busy0), .o_done(done0)
    );

    systolic_feeder #(.W(16), .N(2), .DRAIN(0)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_valid(valid1), .o_ready(ready1), .i_mode(mode1),
        .i_a_col(acol1), .i_b_row(brow1), .o_en(en1), .o_mode(omode1),
        .o_A(oa1), .o_B(ob1), .o_busy(busy1), .o_done(done1)
    );

    typedef struct packed {
        logic        en;
        logic        done;
        logic        ready;
        logic        busy;
        logic [47:0] a;
        logic [47:0] b;
    } rec_t;

    typedef logic [15:0] mat_t [3][3];

    rec_t        q0[$];
    rec_t        q1[$];
    int          m_k[2];
    logic        m_mode[2];
    logic        m_rdy[2];
    logic [15:0] ma[2][3][3];
    logic [15:0] mb[2][3][3];
    int          checks;
    int          errors;
    bit          mon_on;
    int          cyc;

    function automatic int n_of(input int id);
        return (id == 0) ? 3 : 2;
    endfunction

    function automatic int d_of(input int id);
        return (id == 0) ? 6 : 0;
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_rec(input int id, input rec_t r);
        if (id == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // Reference: on the final beat, expand the stored matrices into the whole job's cycle sequence
    task automatic model_edge(input int id, input logic rst, input logic valid, input logic mode_in,
                              input logic [47:0] acol, input logic [47:0] brow);
        int   n;
        int   d;
        rec_t r;
        n = n_of(id);
        d = d_of(id);
        if (rst) begin
            if (id == 0) q0.delete();
            else q1.delete();
            m_k[id]    = 0;
            m_mode[id] = 1'b0;
            m_rdy[id]  = 1'b1;
            return;
        end
        if (valid && m_rdy[id]) begin
            for (int i = 0; i < n; i++) begin
                ma[id][i][m_k[id]] = acol[i*16 +: 16];
                mb[id][m_k[id]][i] = brow[i*16 +: 16];
            end
            if (m_k[id] == 0) m_mode[id] = mode_in;
            if (m_k[id] == n - 1) begin
                m_k[id] = 0;
                for (int t = 0; t < 2 * n - 1 + d; t++) begin
                    r      = '0;
                    r.en   = 1'b1;
                    r.busy = 1'b1;
                    if (t < 2 * n - 1) begin
                        for (int l = 0; l < n; l++) begin
                            if (t - l >= 0 && t - l < n) begin
                                r.a[l*16 +: 16] = ma[id][l][t-l];
                                r.b[l*16 +: 16] = mb[id][t-l][l];
                            end
                        end
                    end
                    push_rec(id, r);
                end
                r      = '0;
                r.done = 1'b1;
                r.busy = 1'b1;
                push_rec(id, r);
            end else begin
                m_k[id] = m_k[id] + 1;
            end
        end
        m_rdy[id] = (qsize(id) == 0);
    endtask

    function automatic rec_t mk(input logic en, input logic dn, input logic rdy, input logic bsy,
                                input logic [47:0] a, input logic [47:0] b);
        rec_t r;
        r.en = en; r.done = dn; r.ready = rdy; r.busy = bsy; r.a = a; r.b = b;
        return r;
    endfunction

    task automatic check_out(input int id, input rec_t act, input logic act_mode);
        rec_t e;
        if (qsize(id) > 0) begin
            if (id == 0) e = q0.pop_front();
            else e = q1.pop_front();
        end else begin
            e       = '0;
            e.ready = 1'b1;
        end
        checks++;
        if (act !== e || act_mode !== m_mode[id]) begin
            errors++;
            $display("FAIL out%0d cyc=%0d got en=%b done=%b rdy=%b busy=%b mode=%b A=%h B=%h exp en=%b done=%b rdy=%b busy=%b mode=%b A=%h B=%h",
                     id, cyc, act.en, act.done, act.ready, act.busy, act_mode, act.a, act.b,
                     e.en, e.done, e.ready, e.busy, m_mode[id], e.a, e.b);
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, rst0, valid0, mode0, acol0, brow0);
        model_edge(1, rst1, valid1, mode1, {16'h0, acol1}, {16'h0, brow1});
    end

    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            check_out(0, mk(en0, done0, ready0, busy0, oa0, ob0), omode0);
            check_out(1, mk(en1, done1, ready1, busy1, {16'h0, oa1}, {16'h0, ob1}), omode1);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int id, input logic v, input logic m, input logic [47:0] a,
                         input logic [47:0] b);
        if (id == 0) begin
            valid0 = v; mode0 = m; acol0 = a; brow0 = b;
        end else begin
            valid1 = v; mode1 = m; acol1 = a[31:0]; brow1 = b[31:0];
        end
    endtask

    task automatic set_rst(input int id, input logic v);
        if (id == 0) rst0 = v;
        else rst1 = v;
    endtask

    task automatic load_job(input int id, input mat_t a, input mat_t b, input logic m_first,
                            input logic m_rest, input int gap);
        int          n;
        logic [47:0] ac;
        logic [47:0] br;
        n = n_of(id);
        for (int k = 0; k < n; k++) begin
            ac = '0;
            br = '0;
            for (int i = 0; i < n; i++) begin
                ac[i*16 +: 16] = a[i][k];
                br[i*16 +: 16] = b[k][i];
            end
            drive(id, 1'b1, (k == 0) ? m_first : m_rest, ac, br);
            step();
            drive(id, 1'b0, 1'b0, '0, '0);
            if (k < n - 1) repeat (gap) step();
        end
    endtask

    task automatic random_phase(input int id, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}));
            set_rst(id, ($urandom_range(0, 59) == 0));
            step();
        end
        drive(id, 1'b0, 1'b0, '0, '0);
        set_rst(id, 1'b0);
    endtask

    mat_t mat_a3, mat_i3, mat_a2, mat_b2, mat_r;

    initial begin
        checks = 0;
        errors = 0;
        mon_on = 1'b0;
        cyc    = 0;
        rst0   = 1'b1;
        rst1   = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        mat_a3 = '{'{16'd1, 16'd2, 16'd3}, '{16'd4, 16'd5, 16'd6}, '{16'd7, 16'd8, 16'd9}};
        mat_i3 = '{'{16'd1, 16'd0, 16'd0}, '{16'd0, 16'd1, 16'd0}, '{16'd0, 16'd0, 16'd1}};
        mat_a2 = '{'{16'd1, 16'd2, 16'd0}, '{16'd3, 16'd4, 16'd0}, '{16'd0, 16'd0, 16'd0}};
        mat_b2 = '{'{16'd5, 16'd6, 16'd0}, '{16'd7, 16'd8, 16'd0}, '{16'd0, 16'd0, 16'd0}};
        repeat (2) @(posedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        step();

        // Basic skew, then gapped load
        load_job(0, mat_a3, mat_i3, 1'b0, 1'b0, 0);
        repeat (15) step();
        load_job(0, mat_a3, mat_i3, 1'b0, 1'b0, 2);
        repeat (15) step();

        // Backpressure: all-ones beats held through STREAM/DRAIN/DONE
        load_job(0, mat_a3, mat_i3, 1'b0, 1'b0, 0);
        drive(0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        repeat (16) step();
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (15) step();

        // Mode latch on beat 0, then a job switching mode back to 0
        load_job(0, mat_a3, mat_i3, 1'b1, 1'b0, 0);
        repeat (15) step();
        load_job(0, mat_i3, mat_a3, 1'b0, 1'b1, 1);
        repeat (15) step();

        // Reset at STREAM t=2, reset during a partial load, then a clean job
        load_job(0, mat_a3, mat_i3, 1'b1, 1'b1, 0);
        repeat (2) step();
        set_rst(0, 1'b1);
        step();
        set_rst(0, 1'b0);
        drive(0, 1'b1, 1'b1, 48'h0001_0002_0003, 48'h0004_0005_0006);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        set_rst(0, 1'b1);
        step();
        set_rst(0, 1'b0);
        load_job(0, mat_i3, mat_a3, 1'b0, 1'b0, 0);
        repeat (15) step();

        // 2x2 with no drain
        load_job(1, mat_a2, mat_b2, 1'b1, 1'b0, 0);
        repeat (6) step();
        load_job(1, mat_b2, mat_a2, 1'b0, 1'b0, 1);
        repeat (6) step();

        // Random matrices with gaps and held valid, then fully random traffic with resets
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    mat_r[r][c] = 16'($urandom());
            load_job(0, mat_r, mat_a3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3));
            load_job(1, mat_r, mat_r, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2));
            repeat (15) step();
        end
        random_phase(0, 300);
        random_phase(1, 200);
        repeat (20) step();

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_queues got %0d/%0d pending records, need 0/0", q0.size(), q1.size());
        end
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream skew and feed stage for the N x N systolic matmul array. Accepts operand matrices A and B one k-slice per handshake beat and buffers a full N x N pair. It then streams A to the array's row-input lanes and B to its column-input lanes, with the diagonal wavefront skew the array requires. It drives the array's enable and mode, zero-pads outside the wavefront, and signals completion after a programmable drain.

Parameters:
W, 16, operand word width (bits)
N, 3, array dimension; also matrix dimension (K = N)
DRAIN, 6, zero-input cycles with o_en high after the last wavefront cycle, so partial sums settle

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  load beat valid
o_ready  output  1  feeder can accept a load beat
i_mode  input  1  array mode; sampled on the first beat (k=0) of a load
i_a_col  input  W*N  A column k: lane i (bits i*W +: W) = A[i][k]
i_b_row  input  W*N  B row k: lane j (bits j*W +: W) = B[k][j]
o_en  output  1  array enable
o_mode  output  1  latched mode to array
o_A  output  W*N  row lanes to array; lane i = bits i*W +: W
o_B  output  W*N  column lanes to array; lane j = bits j*W +: W
o_busy  output  1  high in STREAM, DRAIN and DONE
o_done  output  1  one-cycle pulse at end of job

Behaviour:
- States: LOAD, STREAM, DRAIN, DONE. Reset state is LOAD.
- Reset values: o_ready=1, o_en=0, o_mode=0, o_A=0, o_B=0, o_busy=0, o_done=0. Beat counter, skew counter and buffers are cleared.
- Reset mid-operation (any state) aborts the job. The partial load is discarded and no o_done is produced.
- LOAD:
  - o_ready=1.
  - A beat is accepted on an edge where i_valid=1.
  - Beat k (0..N-1) writes bufA[*][k] and bufB[k][*].
  - i_mode is latched into o_mode on beat k=0.
  - The edge that accepts beat N-1 moves the state to STREAM and resets the skew counter t to 0.
- i_valid while o_ready=0 is ignored; no buffer write occurs.
- STREAM:
  - o_ready=0, o_en=1, o_busy=1. Lasts exactly 2N-1 cycles, t = 0..2N-2.
  - Outputs are registered and valid in the same cycle as t.
  - o_A lane i = bufA[i][t-i] if 0 <= t-i < N, else 0.
  - o_B lane j = bufB[t-j][j] if 0 <= t-j < N, else 0.
  - After t=2N-2 the state moves to DRAIN. If DRAIN=0, it moves directly to DONE.
- DRAIN: o_en=1, o_A=o_B=0, o_ready=0. Lasts exactly DRAIN cycles, then moves to DONE.
- DONE:
  - One cycle: o_done=1, o_en=0, o_A=o_B=0, o_ready=0, o_busy=1. o_mode is held.
  - Next state is LOAD with o_ready=1.
- Total o_en-high run: exactly 2N-1+DRAIN consecutive cycles. It starts the cycle after the accepting edge of the final load beat.
- Latency from last load beat to o_done: 2N-1+DRAIN+1 cycles.
- Data handling:
  - Words pass through unmodified; no arithmetic is performed.
  - Counters are sized clog2(2N-1+DRAIN+1).
  - Buffers are single-banked, so the next load starts only in LOAD.
- Back-to-back jobs:
  - A beat presented on the cycle after DONE is accepted.
  - The next job's o_mode may differ and takes effect at its k=0 beat.
- Non-consecutive load beats (i_valid gaps) are allowed; the beat counter holds while i_valid=0.

Test Plan:
1. Basic skew (N=3, W=16, DRAIN=6). Load A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, 3 consecutive beats. Required:
   - o_A lanes {0,1,2} over the 5 STREAM cycles: {1,0,0}, {2,4,0}, {3,5,7}, {0,6,8}, {0,0,9}.
   - o_B lanes: {1,0,0}, {0,0,0}, {0,1,0}, {0,0,0}, {0,0,1}.
   - o_en high for 11 cycles, then o_done for 1 cycle; o_ready returns to 1 on the following cycle.
2. Gapped load: insert 2 idle cycles (i_valid=0) between beats -> STREAM starts the cycle after the 3rd accepted beat, with output identical to scenario 1.
3. Backpressure: hold i_valid=1 with new data (all 0xFFFF) throughout STREAM, DRAIN and DONE -> no buffer corruption. o_A/o_B match scenario 1. The first 0xFFFF beat is accepted only in the cycle after DONE.
4. Mode latch: i_mode=1 on beat 0 and i_mode=0 on beats 1-2 -> o_mode=1 through the whole job. A second job with i_mode=0 at its beat 0 switches o_mode to 0 on that edge.
5. Reset mid-STREAM: assert i_rst at t=2 for one cycle -> the next cycle shows all outputs at reset values and o_ready=1. No o_done occurs, and a fresh 3-beat load then runs normally.
6. DRAIN=0, N=2: load A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> o_A: {1,0}, {2,3}, {0,4}. o_B: {5,0}, {7,6}, {0,8}. o_en is high for 3 cycles, and o_done is asserted the immediately following cycle.
